// File: rtl/hynoc_ingress_pkg.sv
// hynoc_ingress_pkg: ingress FSM encoding plus header-format helpers shared by the RTL and the bench
//   state_t   : ST_IDLE / ST_REQUEST / ST_XFER / ST_RELEASE / ST_DROP
//   hop_width : bits of one source-route hop field, also the header rotate amount
//   stop_bit  : flit bit index of the end-of-packet marker (MSB, above the payload)
package hynoc_ingress_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_XFER    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DROP    = 3'd4
    } state_t;
    function automatic int hop_width(input int nb_ports);
        return $clog2(nb_ports - 1);
    endfunction
    function automatic int stop_bit(input int payload_width);
        return payload_width;
    endfunction
endpackage

// File: rtl/hynoc_route_decode.sv
// hynoc_route_decode: combinational source-route header decode
//   i_payload : header payload (stop bit excluded)
//   o_dest    : relative egress index from the low hop field
//   o_valid   : o_dest names one of the NB_PORTS-1 other egresses
//   o_rotated : payload rotated right by one hop so the next router finds its field in the low bits
module hynoc_route_decode
    import hynoc_ingress_pkg::*;
#(
    parameter int NB_PORTS      = 5,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int PORT_WIDTH    = hop_width(NB_PORTS)
) (
    input  logic [PAYLOAD_WIDTH-1:0] i_payload,
    output logic [PORT_WIDTH-1:0]    o_dest,
    output logic                     o_valid,
    output logic [PAYLOAD_WIDTH-1:0] o_rotated
);
    assign o_dest    = i_payload[PORT_WIDTH-1:0];
    assign o_valid   = int'(o_dest) <= NB_PORTS - 2;
    assign o_rotated = {i_payload[PORT_WIDTH-1:0], i_payload[PAYLOAD_WIDTH-1:PORT_WIDTH]};
endmodule

// File: rtl/hynoc_ingress.sv
// hynoc_ingress: input half of a hynoc router port; routes each packet from the input FIFO to one egress
//   router_clk / router_srst_n : clock, synchronous active-low reset
//   rclk, ren, rdata, rempty   : first-word-fall-through input FIFO read side
//   to_egress_request          : one-hot request, held from header decode until the stop flit pops
//   to_egress_write / _data    : registered one-hot flit valid and broadcast flit
//   from_egress_grant / _afull : registered grant and almost-full from each egress
module hynoc_ingress
    import hynoc_ingress_pkg::*;
#(
    parameter int NB_PORTS      = 5,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                   router_clk,
    input  logic                   router_srst_n,
    output logic                   rclk,
    output logic                   ren,
    input  logic [PAYLOAD_WIDTH:0] rdata,
    input  logic                   rempty,
    output logic [NB_PORTS-2:0]    to_egress_request,
    output logic [NB_PORTS-2:0]    to_egress_write,
    output logic [PAYLOAD_WIDTH:0] to_egress_data,
    input  logic [NB_PORTS-2:0]    from_egress_grant,
    input  logic [NB_PORTS-2:0]    from_egress_afull
);
    localparam int NE = NB_PORTS - 1;
    localparam int PW = hop_width(NB_PORTS);
    localparam int SB = stop_bit(PAYLOAD_WIDTH);

    state_t                   r_state, w_next;
    logic [PW-1:0]            r_dest, w_dest;
    logic                     r_first, w_valid, w_gnt, w_afull, w_stop;
    logic [PAYLOAD_WIDTH-1:0] w_rot;
    logic [NE-1:0]            w_oh, w_next_oh;

    hynoc_route_decode #(
        .NB_PORTS      (NB_PORTS),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .PORT_WIDTH    (PW)
    ) u_decode (
        .i_payload (rdata[PAYLOAD_WIDTH-1:0]),
        .o_dest    (w_dest),
        .o_valid   (w_valid),
        .o_rotated (w_rot)
    );

    assign rclk      = router_clk;
    assign w_oh      = NE'(1) << r_dest;
    assign w_next_oh = NE'(1) << ((r_state == ST_IDLE) ? w_dest : r_dest);
    // masking with the one-hot keeps an out-of-range dest from selecting anything
    assign w_gnt     = |(from_egress_grant & w_oh);
    assign w_afull   = |(from_egress_afull & w_oh);
    assign w_stop    = rdata[SB];

    always_ff @(posedge router_clk) begin
        if (!router_srst_n) begin
            r_state <= ST_IDLE;
            r_dest  <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && !rempty) begin
                r_dest  <= w_dest;
                r_first <= 1'b1;
            end else if (ren) begin
                r_first <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = rempty ? ST_IDLE : (w_valid ? ST_REQUEST : ST_DROP);
            ST_REQUEST: w_next = w_gnt ? ST_XFER : ST_REQUEST;
            ST_XFER:    w_next = (ren && w_stop) ? ST_RELEASE : ST_XFER;
            // wait for the grant to fall so the arbiter observes the release and rotates
            ST_RELEASE: w_next = w_gnt ? ST_RELEASE : ST_IDLE;
            ST_DROP:    w_next = (ren && w_stop) ? ST_IDLE : ST_DROP;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ren = router_srst_n & !rempty & ((r_state == ST_XFER) ? !w_afull : (r_state == ST_DROP));
    end

    always_ff @(posedge router_clk) begin
        if (!router_srst_n) begin
            to_egress_request <= '0;
            to_egress_write   <= '0;
            to_egress_data    <= '0;
        end else begin
            to_egress_request <= (w_next == ST_REQUEST || w_next == ST_XFER) ? w_next_oh : '0;
            to_egress_write   <= (r_state == ST_XFER && ren) ? w_oh : '0;
            if (r_state == ST_XFER && ren)
                to_egress_data <= {w_stop, r_first ? w_rot : rdata[PAYLOAD_WIDTH-1:0]};
        end
    end
endmodule

// File: tb/tb_hynoc_ingress.sv
// tb_hynoc_ingress: scoreboard bench for hynoc_ingress (5-port instance plus a 6-port drop instance)
module tb_hynoc_ingress;
    import hynoc_ingress_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rclk5, ren5, rempty5;
    logic [32:0] rdata5, dat5;
    logic [3:0]  req5, wr5, gnt5, af5;
    logic        rclk6, ren6, rempty6;
    logic [32:0] rdata6, dat6;
    logic [4:0]  req6, wr6, gnt6, af6;

    hynoc_ingress #(.NB_PORTS(5), .PAYLOAD_WIDTH(32)) u_dut5 (
        .router_clk(clk), .router_srst_n(rst_n), .rclk(rclk5), .ren(ren5),
        .rdata(rdata5), .rempty(rempty5), .to_egress_request(req5),
        .to_egress_write(wr5), .to_egress_data(dat5),
        .from_egress_grant(gnt5), .from_egress_afull(af5)
    );

    hynoc_ingress #(.NB_PORTS(6), .PAYLOAD_WIDTH(32)) u_dut6 (
        .router_clk(clk), .router_srst_n(rst_n), .rclk(rclk6), .ren(ren6),
        .rdata(rdata6), .rempty(rempty6), .to_egress_request(req6),
        .to_egress_write(wr6), .to_egress_data(dat6),
        .from_egress_grant(gnt6), .from_egress_afull(af6)
    );

    logic [32:0] fifo5[$];
    logic [32:0] fifo6[$];
    logic [36:0] exp5[$];
    int checks = 0;
    int errors = 0;
    int act6 = 0;
    int hold_cfg = 0;
    int hold_cnt = 0;
    logic last_ren5 = 1'b0;
    logic last_ren6 = 1'b0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic void drive_fifo();
        rdata5  = (fifo5.size() > 0) ? fifo5[0] : '0;
        rempty5 = (fifo5.size() == 0);
        rdata6  = (fifo6.size() > 0) ? fifo6[0] : '0;
        rempty6 = (fifo6.size() == 0);
    endfunction

    // one clock: sample ren/request before the edge, then model FIFO pops and a PIPELINE=0 egress grant
    task automatic tick();
        logic [3:0] q;
        #1;
        last_ren5 = ren5;
        last_ren6 = ren6;
        q = req5;
        @(posedge clk);
        @(negedge clk);
        if (last_ren5 && fifo5.size() > 0) void'(fifo5.pop_front());
        if (last_ren6 && fifo6.size() > 0) void'(fifo6.pop_front());
        if (q != 4'b0000) begin
            gnt5 = q;
            hold_cnt = hold_cfg;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
        end else begin
            gnt5 = 4'b0000;
        end
        drive_fifo();
    endtask

    // header payload hdr, hand-computed rotated header rot, nbody body flits base, base+1, ...
    task automatic pkt5(input logic [3:0] oh, input logic [31:0] hdr, input logic [31:0] rot,
                        input int nbody, input logic [31:0] base);
        logic s;
        logic [31:0] p;
        s = (nbody == 0);
        fifo5.push_back({s, hdr});
        exp5.push_back({oh, s, rot});
        for (int i = 0; i < nbody; i++) begin
            s = (i == nbody - 1);
            p = base + 32'(i);
            fifo5.push_back({s, p});
            exp5.push_back({oh, s, p});
        end
        drive_fifo();
    endtask

    task automatic run_idle(input string name);
        int n;
        n = 0;
        while (!(u_dut5.r_state == ST_IDLE && fifo5.size() == 0 && exp5.size() == 0) && n < 60) begin
            tick();
            n++;
        end
        chk(name, 64'(n < 60), 64'(1));
    endtask

    always @(negedge clk) begin
        if (wr5 != 4'b0000) begin
            if (exp5.size() == 0) chk("write_unexpected", 64'({wr5, dat5}), 64'(0));
            else chk("write_flit", 64'({wr5, dat5}), 64'(exp5.pop_front()));
        end
        if (wr6 != 5'b00000 || req6 != 5'b00000) act6++;
    end

    initial begin
        int low;
        logic seen_hi, rose;
        logic [3:0] prev_gnt;
        gnt5 = '0; af5 = '0; gnt6 = '0; af6 = '0;
        drive_fifo();
        @(negedge clk);
        tick();
        tick();
        chk("rst_req", 64'(req5), 64'(0));
        chk("rst_wr", 64'(wr5), 64'(0));
        chk("rst_data", 64'(dat5), 64'(0));
        chk("rst_state", 64'(u_dut5.r_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        pkt5(4'b0100, 32'h0000_0006, 32'h8000_0001, 3, 32'h0000_00A0);
        fifo6.push_back({1'b0, 32'h0000_0007});
        fifo6.push_back({1'b0, 32'h0000_0011});
        fifo6.push_back({1'b1, 32'h0000_0012});
        drive_fifo();
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("t1_req", 64'(req5), 64'((k <= 6) ? 4'b0100 : 4'b0000));
            chk("t1_wr", 64'(wr5), 64'((k >= 4 && k <= 7) ? 4'b0100 : 4'b0000));
            if (k == 4) chk("t1_first_data", 64'(dat5), 64'({1'b0, 32'h8000_0001}));
            if (k == 7) chk("t1_release", 64'(u_dut5.r_state), 64'(ST_RELEASE));
            if (k == 1) chk("drop_state", 64'(u_dut6.r_state), 64'(ST_DROP));
        end
        chk("t1_idle", 64'(u_dut5.r_state), 64'(ST_IDLE));
        chk("drop_drained", 64'(fifo6.size()), 64'(0));
        chk("drop_idle", 64'(u_dut6.r_state), 64'(ST_IDLE));

        pkt5(4'b0100, 32'h0000_00F2, 32'h8000_003C, 5, 32'h0000_00B0);
        for (int k = 1; k <= 4; k++) tick();
        af5 = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("afull_ren", 64'(last_ren5), 64'(0));
            chk("afull_req", 64'(req5), 64'(4'b0100));
            if (j > 0) chk("afull_wr", 64'(wr5), 64'(0));
        end
        af5 = 4'b0000;
        run_idle("afull_drain");

        hold_cfg = 2;
        pkt5(4'b0010, 32'h0000_0001, 32'h4000_0000, 1, 32'h0000_00C0);
        pkt5(4'b0010, 32'h0000_0005, 32'h4000_0001, 1, 32'h0000_00D0);
        low = 0; seen_hi = 1'b0; rose = 1'b0; prev_gnt = gnt5;
        for (int k = 0; k < 40 && !rose; k++) begin
            tick();
            if (req5 != 4'b0000 && low > 0) begin
                rose = 1'b1;
                chk("b2b_gnt_low", 64'(prev_gnt), 64'(0));
            end else if (req5 == 4'b0000 && seen_hi) begin
                low++;
            end
            if (req5 != 4'b0000) seen_hi = 1'b1;
            prev_gnt = gnt5;
        end
        chk("b2b_rose", 64'(rose), 64'(1));
        chk("b2b_low_cycles", 64'(low), 64'(5));
        run_idle("b2b_drain");
        hold_cfg = 0;

        pkt5(4'b1000, 32'h0000_0003, 32'hC000_0000, 0, 32'h0);
        tick();
        chk("hdr_only_req", 64'(req5), 64'(4'b1000));
        tick();
        tick();
        tick();
        chk("hdr_only_wr", 64'(wr5), 64'(4'b1000));
        chk("hdr_only_release", 64'(u_dut5.r_state), 64'(ST_RELEASE));
        run_idle("hdr_only_drain");

        pkt5(4'b0001, 32'h0000_0010, 32'h0000_0004, 5, 32'h0000_00E0);
        for (int k = 1; k <= 5; k++) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_ren", 64'(last_ren5), 64'(0));
        rst_n = 1'b1;
        chk("midrst_req", 64'(req5), 64'(0));
        chk("midrst_wr", 64'(wr5), 64'(0));
        chk("midrst_data", 64'(dat5), 64'(0));
        chk("midrst_state", 64'(u_dut5.r_state), 64'(ST_IDLE));
        chk("midrst_fifo_kept", 64'(fifo5.size()), 64'(4));
        fifo5.delete();
        exp5.delete();
        pkt5(4'b0100, 32'h0000_0002, 32'h8000_0000, 0, 32'h0);
        tick();
        chk("postrst_req", 64'(req5), 64'(4'b0100));
        run_idle("postrst_drain");

        tick();
        tick();
        chk("drop_no_activity", 64'(act6), 64'(0));
        chk("sb_empty", 64'(exp5.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
